tx_byte_sequencer: RTL and testbench
====================================

Name: tx_byte_sequencer

Overview:
- Sits directly downstream of the button/latch stage and directly upstream of the UART TX serializer.
- On a one-cycle start pulse, captures the latched start byte, delay code and byte count.
- Emits a stream of incrementing bytes to the serializer over a valid/ready handshake.
- Inserts a programmable inter-byte gap counted in baud-tick enables; reports progress and completion.

Parameters:
- STEP_TICKS, 5760: ce pulses per 0.1 s gap step (57600 baud tick / 10).
- CNT_W, 15: width of byte count and bytes_sent.
- GAP_W, 24: width of gap counter; must hold 20*STEP_TICKS.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  baud-rate tick enable; gap timing only
- start  in  1  one-cycle request from latch stage
- data_in  in  8  first byte value
- delay_code  in  2  gap select: 00=0, 01=5, 10=10, 11=20 steps of 0.1 s
- byte_count  in  CNT_W  payload bytes to send (1..32767)
- abort  in  1  synchronous cancel
- tx_data  out  8  byte to serializer
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  serializer accepts byte
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after final byte accepted
- bytes_sent  out  CNT_W  payload bytes accepted in current/last run

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - tx_data=0, tx_valid=0, busy=0, done=0, bytes_sent=0.
  - Gap counter and remaining counter are cleared.
- FSM runs every clk. The gap counter advances only on cycles with ce=1.
- States: IDLE, SEND, GAP, FIN.
- IDLE:
  - start=1 with byte_count!=0 at edge N:
    - Capture data_in, delay_code and byte_count; clear bytes_sent.
    - Set tx_data=data_in and tx_valid=1 from edge N. State -> SEND.
  - start=1 with byte_count==0: ignored, no done.
  - start outside IDLE: ignored.
- SEND:
  - tx_valid held high and tx_data held stable until tx_ready=1 is sampled; transfer happens on that edge.
  - On transfer, tx_valid drops and bytes_sent increments.
  - If it was the last byte, state -> FIN.
  - Otherwise tx_data <= tx_data+1 (mod 256, wraps FF->00).
    - Gap of 0: state -> SEND with tx_valid=1 next edge, i.e. one idle cycle between bytes.
    - Gap non-zero: load gap = steps*STEP_TICKS, state -> GAP.
- GAP:
  - Decrement on each ce=1.
  - When the count reaches 0 on a ce edge, state -> SEND with tx_valid=1.
  - ce=0 freezes the count.
- FIN: done=1 for exactly one cycle, busy=0 from the following edge, state -> IDLE.
- bytes_sent holds its value after FIN until the next accepted start.
- abort=1 in any state: next edge goes to IDLE, tx_valid=0, no done, bytes_sent retains partial count.
  - abort takes priority over tx_ready in the same cycle; that byte is not counted.
- start and abort in the same IDLE cycle: abort wins, start is ignored.
- The delay_code to step mapping is combinational on the captured code; steps are 5-bit.
- The gap product is computed at GAP_W width with no truncation.

Optional Feature:
- Macro: TX_SEQ_CHECKSUM_EN.
- Defined:
  - A running XOR of all payload bytes is kept.
  - After the last payload byte (and one gap, if non-zero), one extra byte equal to the XOR is sent via SEND.
  - bytes_sent excludes the checksum byte. done pulses after the checksum byte is accepted.
  - abort discards the checksum.
- Undefined: no XOR logic; done pulses after the last payload byte.

Decomposition:
- Package tx_seq_pkg:
  - State enum typedef (IDLE, SEND, GAP, FIN, plus CKSUM under the macro).
  - STEP_TICKS default constant.
  - Function mapping delay_code to steps (0, 5, 10, 20).
- Sub-module tx_gap_timer:
  - Loadable GAP_W down-counter gated by ce.
  - Outputs an expired flag.

Test Plan:
- Reset mid-SEND (tx_valid=1): assert reset_n=0 -> all outputs 0 immediately; no transfer after release.
- start, data_in=8'hFE, byte_count=4, delay_code=00, tx_ready always 1 -> tx_data FE, FF, 00, 01 with one idle cycle between; done pulses once; bytes_sent=4.
- delay_code=01, STEP_TICKS=4 (test override), byte_count=2, ce every 3rd clk -> second tx_valid rises exactly after 20 ce pulses following the first transfer.
- tx_ready held 0 for 50 cycles -> tx_valid stays 1 and tx_data stable; a second start in that window is ignored.
- byte_count=0 start -> no tx_valid, no done. Abort during GAP at byte 3 of 10 -> IDLE, bytes_sent=3, no done.
- With TX_SEQ_CHECKSUM_EN: data_in=8'h10, byte_count=3 -> bytes 10, 11, 12, then checksum 8'h13; bytes_sent=3; done after the checksum byte.

Source files
------------

// File: rtl/tx_seq_pkg.sv
// Shared types and helpers for the UART TX byte sequencer.
// The TX_SEQ_CHECKSUM_EN macro adds the CKSUM state for the trailing XOR byte.
package tx_seq_pkg;

    localparam int STEP_TICKS_DEF = 5760;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_GAP   = 3'd2,
        ST_FIN   = 3'd3
`ifdef TX_SEQ_CHECKSUM_EN
        ,
        ST_CKSUM = 3'd4
`endif
    } state_t;

    // Gap length in 0.1 s steps for each delay code.
    function automatic logic [4:0] delay_steps(input logic [1:0] code);
        logic [4:0] steps;
        case (code)
            2'b00:   steps = 5'd0;
            2'b01:   steps = 5'd5;
            2'b10:   steps = 5'd10;
            default: steps = 5'd20;
        endcase
        return steps;
    endfunction

endpackage

// File: rtl/tx_gap_timer.sv
// Loadable down-counter advanced only on baud-tick enables.
// expired flags the ce edge on which the count reaches zero.
module tx_gap_timer #(
    parameter int GAP_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             load,
    input  logic [GAP_W-1:0] load_val,
    output logic             expired
);

    localparam logic [GAP_W-1:0] ONE = {{(GAP_W-1){1'b0}}, 1'b1};

    logic [GAP_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (ce && count != '0)
            count <= count - ONE;
    end

    assign expired = ce && !load && (count == ONE);

endmodule

// File: rtl/tx_byte_sequencer.sv
// Streams incrementing bytes to the UART serializer with programmable gaps.
// Define TX_SEQ_CHECKSUM_EN to append an XOR checksum byte after the payload.
module tx_byte_sequencer
    import tx_seq_pkg::*;
#(
    parameter int STEP_TICKS = STEP_TICKS_DEF,
    parameter int CNT_W      = 15,
    parameter int GAP_W      = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             start,
    input  logic [7:0]       data_in,
    input  logic [1:0]       delay_code,
    input  logic [CNT_W-1:0] byte_count,
    input  logic             abort,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bytes_sent
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [1:0]       code_q;
    logic [CNT_W-1:0] remaining;
    logic [GAP_W-1:0] gap_len;
    logic             gap_zero;
    logic             xfer;
    logic             last;
    logic             gap_load;
    logic             gap_expired;

    assign gap_len  = GAP_W'(delay_steps(code_q)) * GAP_W'(STEP_TICKS);
    assign gap_zero = (gap_len == '0);
    assign xfer     = tx_valid && tx_ready;
    assign last     = (remaining == CNT_ONE);
    assign busy     = (state != ST_IDLE);

`ifdef TX_SEQ_CHECKSUM_EN
    logic [7:0] xor_acc;
    logic       cksum_pending;

    // The checksum byte also waits out one gap, so load on every payload transfer.
    assign gap_load = abort || (state == ST_SEND && xfer && !gap_zero);
`else
    assign gap_load = abort || (state == ST_SEND && xfer && !last && !gap_zero);
`endif

    tx_gap_timer #(.GAP_W(GAP_W)) u_gap (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce       (ce),
        .load     (gap_load),
        .load_val (abort ? '0 : gap_len),
        .expired  (gap_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            done       <= 1'b0;
            bytes_sent <= '0;
            remaining  <= '0;
            code_q     <= 2'b00;
`ifdef TX_SEQ_CHECKSUM_EN
            xor_acc       <= 8'h00;
            cksum_pending <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Abort beats a same-cycle handshake; the byte is not counted.
                state    <= ST_IDLE;
                tx_valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && byte_count != '0) begin
                            tx_data    <= data_in;
                            tx_valid   <= 1'b1;
                            code_q     <= delay_code;
                            remaining  <= byte_count;
                            bytes_sent <= '0;
                            state      <= ST_SEND;
`ifdef TX_SEQ_CHECKSUM_EN
                            xor_acc       <= 8'h00;
                            cksum_pending <= 1'b0;
`endif
                        end
                    end
                    ST_SEND: begin
                        if (!tx_valid) begin
                            tx_valid <= 1'b1;
                        end else if (tx_ready) begin
                            tx_valid   <= 1'b0;
                            bytes_sent <= bytes_sent + CNT_ONE;
                            remaining  <= remaining - CNT_ONE;
`ifdef TX_SEQ_CHECKSUM_EN
                            xor_acc <= xor_acc ^ tx_data;
                            if (last) begin
                                tx_data       <= xor_acc ^ tx_data;
                                cksum_pending <= 1'b1;
                                state         <= gap_zero ? ST_CKSUM : ST_GAP;
                            end else begin
                                tx_data <= tx_data + 8'd1;
                                state   <= gap_zero ? ST_SEND : ST_GAP;
                            end
`else
                            if (last) begin
                                state <= ST_FIN;
                                done  <= 1'b1;
                            end else begin
                                tx_data <= tx_data + 8'd1;
                                state   <= gap_zero ? ST_SEND : ST_GAP;
                            end
`endif
                        end
                    end
                    ST_GAP: begin
                        if (gap_expired) begin
                            tx_valid <= 1'b1;
`ifdef TX_SEQ_CHECKSUM_EN
                            state <= cksum_pending ? ST_CKSUM : ST_SEND;
`else
                            state <= ST_SEND;
`endif
                        end
                    end
`ifdef TX_SEQ_CHECKSUM_EN
                    ST_CKSUM: begin
                        if (!tx_valid) begin
                            tx_valid <= 1'b1;
                        end else if (tx_ready) begin
                            tx_valid      <= 1'b0;
                            cksum_pending <= 1'b0;
                            state         <= ST_FIN;
                            done          <= 1'b1;
                        end
                    end
`endif
                    ST_FIN:  state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_byte_sequencer.sv
// Directed bench for tx_byte_sequencer: vector table plus multi-cycle corner sequences.
// Build with TX_SEQ_CHECKSUM_EN defined to exercise the checksum byte.
module tb_tx_byte_sequencer;

    localparam int CNT_W = 15;
`ifdef TX_SEQ_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             ce = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       data_in = 8'h00;
    logic [1:0]       delay_code = 2'b00;
    logic [CNT_W-1:0] byte_count = '0;
    logic             abort = 1'b0;
    logic             tx_ready = 1'b0;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] bytes_sent;

    tx_byte_sequencer #(.STEP_TICKS(4), .CNT_W(CNT_W), .GAP_W(24)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .start      (start),
        .data_in    (data_in),
        .delay_code (delay_code),
        .byte_count (byte_count),
        .abort      (abort),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .bytes_sent (bytes_sent)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [7:0] got[$];
    int gotc[$];

    always @(posedge clk) cyc++;

    // Inputs change at negedge; sample 2 time units later, ahead of the next posedge.
    always begin
        @(negedge clk);
        #2;
        if (reset_n && tx_valid && tx_ready && !abort) begin
            got.push_back(tx_data);
            gotc.push_back(cyc);
        end
        if (reset_n && done) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        got.delete();
        gotc.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [7:0] d, input logic [1:0] dc, input int cnt);
        @(negedge clk);
        start = 1'b1;
        data_in = d;
        delay_code = dc;
        byte_count = CNT_W'(cnt);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (i == budget) chk({name, "_timeout"}, 32'd1, 32'd0);
        #3;
    endtask

    typedef struct {
        logic [7:0] data;
        int         cnt;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
        int         exp_sent;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int errs;
        int pulses;
        logic any_valid;

        vecs[0] = '{data: 8'hFE, cnt: 4, exp_first: 8'hFE, exp_last: 8'h01, exp_sent: 4};
        vecs[1] = '{data: 8'h00, cnt: 1, exp_first: 8'h00, exp_last: 8'h00, exp_sent: 1};
        vecs[2] = '{data: 8'h7F, cnt: 3, exp_first: 8'h7F, exp_last: 8'h81, exp_sent: 3};
        vecs[3] = '{data: 8'hFF, cnt: 2, exp_first: 8'hFF, exp_last: 8'h00, exp_sent: 2};

        // Reset state
        @(negedge clk);
        chk("rst_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_sent", bytes_sent, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Back-to-back runs, gap code 00, serializer always ready
        tx_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            clear_log();
            do_start(vecs[v].data, 2'b00, vecs[v].cnt);
            wait_idle($sformatf("v%0d", v), 200);
            chk($sformatf("v%0d_nbytes", v), got.size(), vecs[v].cnt + CK);
            if (got.size() >= vecs[v].cnt) begin
                chk($sformatf("v%0d_first", v), got[0], vecs[v].exp_first);
                chk($sformatf("v%0d_last", v), got[vecs[v].cnt-1], vecs[v].exp_last);
                errs = 0;
                for (int i = 0; i < vecs[v].cnt; i++)
                    if (got[i] !== 8'(vecs[v].data + 8'(i))) errs++;
                chk($sformatf("v%0d_incr", v), errs, 0);
            end
            errs = 0;
            for (int i = 1; i < gotc.size(); i++)
                if (gotc[i] - gotc[i-1] != 2) errs++;
            chk($sformatf("v%0d_spacing", v), errs, 0);
            chk($sformatf("v%0d_sent", v), bytes_sent, vecs[v].exp_sent);
            chk($sformatf("v%0d_done", v), done_cnt, 1);
        end

        // Reset while a byte is pending
        clear_log();
        tx_ready = 1'b0;
        do_start(8'hAA, 2'b00, 3);
        @(negedge clk);
        chk("midrst_pre_valid", tx_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_valid", tx_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_data", tx_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tx_ready = 1'b1;
        any_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (tx_valid || busy) any_valid = 1'b1;
        end
        #3;
        chk("midrst_quiet", any_valid, 0);
        chk("midrst_nbytes", got.size(), 0);

        // Gap code 01: 5 steps x 4 ticks = 20 ce pulses, ce on every 3rd clock
        clear_log();
        tx_ready = 1'b1;
        ce = 1'b0;
        do_start(8'h40, 2'b01, 2);
        pulses = 0;
        any_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_valid) begin
                any_valid = 1'b1;
                break;
            end
            ce = (i % 3 == 2);
            if (ce) pulses++;
        end
        ce = 1'b0;
        chk("gap_rose", any_valid, 1);
        chk("gap_pulses", pulses, 20);
        chk("gap_data2", tx_data, 8'h41);
        ce = 1'b1;
        wait_idle("gap", 400);
        ce = 1'b0;
        chk("gap_sent", bytes_sent, 2);
        chk("gap_done", done_cnt, 1);

        // Serializer stalls for 50 cycles; a start in the window is ignored
        clear_log();
        tx_ready = 1'b0;
        do_start(8'h55, 2'b00, 2);
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            start = (i == 10);
            data_in = 8'h99;
            byte_count = CNT_W'(5);
            if (!(tx_valid === 1'b1 && tx_data === 8'h55)) errs++;
        end
        start = 1'b0;
        chk("stall_hold", errs, 0);
        tx_ready = 1'b1;
        wait_idle("stall", 200);
        chk("stall_nbytes", got.size(), 2 + CK);
        if (got.size() >= 2) begin
            chk("stall_b0", got[0], 8'h55);
            chk("stall_b1", got[1], 8'h56);
        end
        chk("stall_sent", bytes_sent, 2);

        // byte_count == 0 is ignored
        clear_log();
        do_start(8'h33, 2'b00, 0);
        any_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (tx_valid || busy) any_valid = 1'b1;
        end
        #3;
        chk("zero_quiet", any_valid, 0);
        chk("zero_done", done_cnt, 0);
        chk("zero_sent_kept", bytes_sent, 2);

        // Abort while in the gap after byte 3 of 10
        clear_log();
        ce = 1'b1;
        do_start(8'h20, 2'b01, 10);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (got.size() >= 3) break;
        end
        ce = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_in_gap", {busy, tx_valid}, 2'b10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", tx_valid, 0);
        chk("abort_sent", bytes_sent, 3);
        repeat (4) @(negedge clk);
        #3;
        chk("abort_done", done_cnt, 0);

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        byte_count = CNT_W'(5);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("startabort_idle", {busy, tx_valid}, 2'b00);

`ifdef TX_SEQ_CHECKSUM_EN
        // 10 ^ 11 ^ 12 = 13
        clear_log();
        do_start(8'h10, 2'b00, 3);
        wait_idle("cksum", 200);
        chk("cksum_nbytes", got.size(), 4);
        if (got.size() == 4) chk("cksum_byte", got[3], 8'h13);
        chk("cksum_sent", bytes_sent, 3);
        chk("cksum_done", done_cnt, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
